vram_port: RTL and testbench

VRAM_PORT -- requirements
Module: vram_port

---
 rtl/vram_port_pkg.sv | 15 +
 rtl/vram_wq.sv | 70 +++++++
 rtl/vram_port.sv | 135 +++++++++++++
 tb/tb_vram_port.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vram_port_pkg.sv
// Shared definitions for the VRAM arbitration port and the tile fetcher.
// Holds the CPU read sequencer state encoding and the default map geometry.
package vram_port_pkg;

    localparam int unsigned VRAM_AW = 12;
    localparam int unsigned VRAM_DW = 8;

    typedef enum logic [1:0] {
        RD_IDLE,
        RD_DRAIN,
        RD_ISSUE,
        RD_RESP
    } rd_state_e;

endpackage

// File: rtl/vram_wq.sv
// Synchronous FIFO buffering CPU writes until a free RAM slot appears.
// Push is refused when full, pop is refused when empty; both may occur together.
module vram_wq #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 20,
    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CW-1:0]    count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             push_ok, pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign dout_o  = mem_q[rd_ptr_q];

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/vram_port.sv
// Single-port VRAM arbiter: video reads, then CPU reads, then queued CPU writes.
// Video latency is fixed; CPU reads drain the write queue before issuing.
module vram_port
    import vram_port_pkg::*;
#(
    parameter int unsigned AW       = VRAM_AW,
    parameter int unsigned DW       = VRAM_DW,
    parameter int unsigned WQ_DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          vid_req,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_data,
    output logic          vid_valid,
    input  logic          cpu_we,
    input  logic          cpu_rd,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic          cpu_wait,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
);

    localparam int unsigned CW = $clog2(WQ_DEPTH) + 1;

    rd_state_e        rd_state_q;
    logic [AW-1:0]    rd_addr_q;
    logic [DW-1:0]    cpu_rdata_q;
    logic             cpu_rvalid_q;
    logic             vid_pend_q;
    logic [DW-1:0]    vid_data_q;
    logic             vid_valid_q;

    logic             wq_push, wq_pop, wq_full, wq_empty;
    logic [CW-1:0]    wq_count;
    logic [AW+DW-1:0] wq_head;
    logic             rd_issue, rd_accept;

    assign cpu_wait  = (wq_count == CW'(WQ_DEPTH)) || (rd_state_q != RD_IDLE);
    assign rd_issue  = (rd_state_q == RD_ISSUE) && !vid_req;
    assign wq_pop    = !vid_req && !rd_issue && !wq_empty;
    assign wq_push   = cpu_we && !cpu_wait && !wq_full;
    assign rd_accept = cpu_rd && !cpu_we && !cpu_wait;

    vram_wq #(
        .DEPTH (WQ_DEPTH),
        .WIDTH (AW + DW)
    ) u_wq (
        .clk_i   (clk),
        .rst_ni  (reset_n),
        .push_i  (wq_push),
        .din_i   ({cpu_addr, cpu_wdata}),
        .pop_i   (wq_pop),
        .dout_o  (wq_head),
        .full_o  (wq_full),
        .empty_o (wq_empty),
        .count_o (wq_count)
    );

    // One RAM slot per cycle; idle slots drive zeros with the write strobe low.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        if (vid_req) begin
            mem_addr = vid_addr;
        end else if (rd_issue) begin
            mem_addr = rd_addr_q;
        end else if (wq_pop) begin
            mem_addr  = wq_head[AW+DW-1:DW];
            mem_wdata = wq_head[DW-1:0];
            mem_we    = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_pend_q  <= 1'b0;
            vid_data_q  <= '0;
            vid_valid_q <= 1'b0;
        end else begin
            vid_pend_q  <= vid_req;
            vid_valid_q <= vid_pend_q;
            if (vid_pend_q) begin
                vid_data_q <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_state_q   <= RD_IDLE;
            rd_addr_q    <= '0;
            cpu_rdata_q  <= '0;
            cpu_rvalid_q <= 1'b0;
        end else begin
            cpu_rvalid_q <= 1'b0;
            case (rd_state_q)
                RD_IDLE: begin
                    if (rd_accept) begin
                        rd_addr_q  <= cpu_addr;
                        rd_state_q <= RD_DRAIN;
                    end
                end
                RD_DRAIN: begin
                    if (wq_empty) begin
                        rd_state_q <= RD_ISSUE;
                    end
                end
                RD_ISSUE: begin
                    if (rd_issue) begin
                        rd_state_q <= RD_RESP;
                    end
                end
                RD_RESP: begin
                    cpu_rdata_q  <= mem_rdata;
                    cpu_rvalid_q <= 1'b1;
                    rd_state_q   <= RD_IDLE;
                end
                default: rd_state_q <= RD_IDLE;
            endcase
        end
    end

    assign vid_data   = vid_data_q;
    assign vid_valid  = vid_valid_q;
    assign cpu_rdata  = cpu_rdata_q;
    assign cpu_rvalid = cpu_rvalid_q;

endmodule

// File: tb/tb_vram_port.sv
// Bench for vram_port: behavioural sync RAM, shadow memory and scoreboards
// for video reads, CPU reads and RAM writes, plus table-driven slot checks.
module tb_vram_port;

    localparam int AW  = 12;
    localparam int DW  = 8;
    localparam int WQD = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          vid_req;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_data;
    logic          vid_valid;
    logic          cpu_we, cpu_rd;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_wait;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_rvalid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_we;
    logic [DW-1:0] mem_rdata;

    always #5 clk = ~clk;

    vram_port #(.AW(AW), .DW(DW), .WQ_DEPTH(WQD)) dut (
        .clk(clk), .reset_n(reset_n),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_data(vid_data), .vid_valid(vid_valid),
        .cpu_we(cpu_we), .cpu_rd(cpu_rd), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_wait(cpu_wait), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
    );

    logic [7:0] ram    [4096];
    logic [7:0] shadow [4096];

    always @(posedge clk) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    function automatic logic [7:0] pre(input logic [11:0] a);
        return a[7:0] ^ a[11:4];
    endfunction

    int checks = 0;
    int errors = 0;
    int cyc_n  = 0;
    always @(posedge clk) cyc_n++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc_n);
        end
    endtask

    typedef struct {logic [7:0] d; int cyc;} exp_t;
    typedef struct {logic [11:0] a; logic [7:0] d;} wr_t;
    exp_t vq[$];
    exp_t rq[$];
    wr_t  wq[$];

    // Scoreboard monitors sample mid-cycle; inputs change 2 time units after posedge.
    always @(negedge clk) begin : mon
        exp_t e;
        wr_t  w;
        if (reset_n) begin
            if (vid_valid) begin
                if (vq.size() == 0) chk("vid_unexpected_valid", 1, 0);
                else begin
                    e = vq.pop_front();
                    chk("vid_data", vid_data, e.d);
                    chk("vid_latency", cyc_n, e.cyc);
                end
            end
            if (cpu_rvalid) begin
                if (rq.size() == 0) chk("cpu_unexpected_rvalid", 1, 0);
                else begin
                    e = rq.pop_front();
                    chk("cpu_rdata", cpu_rdata, e.d);
                    if (e.cyc >= 0) chk("cpu_rd_latency", cyc_n, e.cyc);
                end
            end
            if (mem_we) begin
                if (wq.size() == 0) chk("unexpected_mem_we", 1, 0);
                else begin
                    w = wq.pop_front();
                    chk("wr_addr", mem_addr, w.a);
                    chk("wr_data", mem_wdata, w.d);
                    shadow[w.a] = w.d;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input logic vr, input logic [11:0] va, input logic we, input logic rd,
                         input logic [11:0] ca, input logic [7:0] wd);
        vid_req = vr; vid_addr = va; cpu_we = we; cpu_rd = rd; cpu_addr = ca; cpu_wdata = wd;
        if (vr) vq.push_back('{shadow[va], cyc_n + 2});
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while ((vq.size() + rq.size() + wq.size()) != 0 && n < 20) begin
            drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
            tick();
            n++;
        end
        chk({name, "_drained"}, vq.size() + rq.size() + wq.size(), 0);
    endtask

    task automatic chk_reset_outputs(input string name);
        chk({name, "_vid_valid"}, vid_valid, 0);
        chk({name, "_vid_data"}, vid_data, 0);
        chk({name, "_cpu_rvalid"}, cpu_rvalid, 0);
        chk({name, "_cpu_rdata"}, cpu_rdata, 0);
        chk({name, "_mem_we"}, mem_we, 0);
        chk({name, "_cpu_wait"}, cpu_wait, 0);
    endtask

    // CPU read launched while video holds the slot for nv cycles.
    task automatic rd_with_vid(input int nv, input logic [11:0] ra, input logic [7:0] exp);
        int issue;
        logic vr;
        issue = (nv > 2) ? nv : 2;
        for (int idx = 0; idx <= issue; idx++) begin
            vr = (idx < nv);
            drive(vr, 12'h400 + 12'(idx), 1'b0, (idx == 0), ra, '0);
            #1;
            if (idx == issue) begin
                chk("rd_issue_addr", mem_addr, ra);
                chk("rd_issue_we", mem_we, 0);
                rq.push_back('{exp, cyc_n + 2});
            end else begin
                chk("rd_slot_addr", mem_addr, vr ? (12'h400 + 12'(idx)) : 12'h000);
            end
            if (idx > 0) chk("rd_pending_wait", cpu_wait, 1);
            tick();
        end
        drain("rd_vid");
    endtask

    typedef struct {
        logic vr; logic [11:0] va; logic we; logic [11:0] ca; logic [7:0] wd;
        logic exp_wait; logic exp_we; logic [11:0] exp_maddr; logic [7:0] exp_mwd;
    } vec_t;
    vec_t vecs[24];

    initial begin
        for (int i = 0; i < 16; i++)
            vecs[i] = '{1'b1, 12'h400 + 12'(i), 1'b0, 12'h000, 8'h00, 1'b0, 1'b0, 12'h400 + 12'(i), 8'h00};
        for (int i = 0; i < 5; i++)
            vecs[16+i] = '{1'b1, 12'h3F0, 1'b1, 12'h100 + 12'(i), 8'h30 + 8'(i), (i == 4), 1'b0, 12'h3F0, 8'h00};
        vecs[21] = '{1'b1, 12'h3F0, 1'b1, 12'h104, 8'h34, 1'b1, 1'b0, 12'h3F0, 8'h00};
        vecs[22] = '{1'b0, 12'h000, 1'b1, 12'h104, 8'h34, 1'b1, 1'b1, 12'h100, 8'h30};
        vecs[23] = '{1'b0, 12'h000, 1'b1, 12'h104, 8'h34, 1'b0, 1'b1, 12'h101, 8'h31};

        for (int a = 0; a < 4096; a++) begin
            ram[a]    = pre(12'(a));
            shadow[a] = pre(12'(a));
        end
        reset_n = 1'b0;
        vid_req = 1'b0; vid_addr = '0; cpu_we = 1'b0; cpu_rd = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        repeat (3) tick();
        chk_reset_outputs("por");
        reset_n = 1'b1;
        tick();

        // Video sweep, then write burst behind continuous video and the full-queue pop.
        for (int i = 0; i < 24; i++) begin
            drive(vecs[i].vr, vecs[i].va, vecs[i].we, 1'b0, vecs[i].ca, vecs[i].wd);
            #1;
            chk("vec_cpu_wait", cpu_wait, vecs[i].exp_wait);
            chk("vec_mem_we", mem_we, vecs[i].exp_we);
            chk("vec_mem_addr", mem_addr, vecs[i].exp_maddr);
            chk("vec_mem_wdata", mem_wdata, vecs[i].exp_mwd);
            if (vecs[i].we && !vecs[i].exp_wait) wq.push_back('{vecs[i].ca, vecs[i].wd});
            tick();
        end
        drain("burst");

        // Read-after-write to the same address.
        drive(1'b0, '0, 1'b1, 1'b0, 12'h812, 8'hA5);
        wq.push_back('{12'h812, 8'hA5});
        #1 chk("raw_wr_wait", cpu_wait, 0);
        tick();
        drive(1'b0, '0, 1'b0, 1'b1, 12'h812, '0);
        #1;
        chk("raw_pop_we", mem_we, 1);
        chk("raw_rd_wait", cpu_wait, 0);
        rq.push_back('{8'hA5, -1});
        tick();
        drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
        #1 chk("raw_outstanding_wait", cpu_wait, 1);
        tick();
        drain("raw");

        rd_with_vid(2, 12'h812, 8'hA5);
        rd_with_vid(4, 12'h40A, pre(12'h40A));

        // Video read of an address with a queued write sees the old data.
        drive(1'b1, 12'h405, 1'b1, 1'b0, 12'h405, 8'hEE);
        wq.push_back('{12'h405, 8'hEE});
        tick();
        repeat (2) begin
            drive(1'b1, 12'h405, 1'b0, 1'b0, '0, '0);
            #1 chk("nofwd_we", mem_we, 0);
            tick();
        end
        drain("nofwd_old");
        drive(1'b1, 12'h405, 1'b0, 1'b0, '0, '0);
        tick();
        drain("nofwd_new");

        // Reset with three queued writes and a read parked in DRAIN.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 12'h3F0, 1'b1, 1'b0, 12'h200 + 12'(i), 8'h60 + 8'(i));
            tick();
        end
        drive(1'b1, 12'h3F0, 1'b0, 1'b1, 12'h200, '0);
        tick();
        drive(1'b1, 12'h3F0, 1'b0, 1'b0, '0, '0);
        #1 chk("drain_wait", cpu_wait, 1);
        tick();
        reset_n = 1'b0;
        vid_req = 1'b0; cpu_we = 1'b0; cpu_rd = 1'b0;
        vq.delete();
        rq.delete();
        #1 chk_reset_outputs("mid_rst");
        repeat (2) tick();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, '0, 1'b0, 1'b0, '0, '0);
            #1;
            chk("post_rst_mem_we", mem_we, 0);
            chk("post_rst_wait", cpu_wait, 0);
            if (i == 0) chk_reset_outputs("post_rst");
            tick();
        end
        drain("end");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
